// File: rtl/demux_pkg.sv
// Shared defaults and select-width helper for the demux_stream block family.
package demux_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int N_DEF     = 8;

  // Width of a channel index; at least one bit so single-channel selects stay legal.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_ptr.sv
// Rotating channel pointer used by demux_stream in AUTO mode; wraps N-1 -> 0.
module demux_ptr
  import demux_pkg::*;
#(
  parameter  int N    = N_DEF,
  localparam int SELW = sel_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  output logic [SELW-1:0] ptr
);

  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      if (ptr_q == SELW'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + SELW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/demux_stream.sv
// One-word registered stream demultiplexer with per-channel valid/ready.
// Optional out-of-range error pulse port enabled by macro DEMUX_STREAM_ERR_EN.
module demux_stream
  import demux_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int N     = N_DEF,
  parameter  int AUTO  = 0,
  localparam int SELW  = sel_w(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]    in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready
`ifdef DEMUX_STREAM_ERR_EN
  ,
  output logic               err
`endif
);

  localparam logic [SELW:0] N_L = (SELW + 1)'(N);

  logic             hold_v_q, hold_v_d;
  logic [WIDTH-1:0] hold_d_q, hold_d_d;
  logic [SELW-1:0]  hold_s_q, hold_s_d;
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  target;
  logic             accept;
  logic             consume;
  logic             in_range;

  assign consume  = hold_v_q && out_ready[hold_s_q];
  assign in_ready = !hold_v_q || out_ready[hold_s_q];
  assign accept   = in_valid && in_ready;
  assign target   = (AUTO != 0) ? ptr : in_sel;
  assign in_range = ({1'b0, target} < N_L);

  generate
    if (AUTO != 0) begin : g_auto
      demux_ptr #(.N(N)) u_ptr (
        .clk (clk),
        .rst (rst),
        .inc (accept),
        .ptr (ptr)
      );
    end else begin : g_sel
      assign ptr = '0;
    end
  endgenerate

  // A consume frees the slot; an in-range accept in the same edge refills it.
  always_comb begin
    hold_v_d = hold_v_q;
    hold_d_d = hold_d_q;
    hold_s_d = hold_s_q;
    if (consume) begin
      hold_v_d = 1'b0;
    end
    if (accept && in_range) begin
      hold_v_d = 1'b1;
      hold_d_d = in_data;
      hold_s_d = target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q <= 1'b0;
      hold_d_q <= '0;
      hold_s_q <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      hold_d_q <= hold_d_d;
      hold_s_q <= hold_s_d;
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (hold_s_q == SELW'(i)) begin
        out_valid[i]                = hold_v_q;
        out_data[i*WIDTH +: WIDTH]  = hold_d_q;
      end
    end
  end

`ifdef DEMUX_STREAM_ERR_EN
  logic err_q, err_d;

  assign err_d = accept && !in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Directed self-checking bench for demux_stream: N=8 select mode, N=3 AUTO mode, N=6 out-of-range.
module tb_demux_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: N=8, WIDTH=8, select mode
  logic [7:0]  a_in_data;
  logic [2:0]  a_in_sel;
  logic        a_in_valid, a_in_ready;
  logic [63:0] a_out_data;
  logic [7:0]  a_out_valid, a_out_ready;

  // Instance B: N=3, AUTO mode
  logic [7:0]  b_in_data;
  logic [1:0]  b_in_sel;
  logic        b_in_valid, b_in_ready;
  logic [23:0] b_out_data;
  logic [2:0]  b_out_valid, b_out_ready;

  // Instance C: N=6, select mode with unreachable select codes
  logic [7:0]  c_in_data;
  logic [2:0]  c_in_sel;
  logic        c_in_valid, c_in_ready;
  logic [47:0] c_out_data;
  logic [5:0]  c_out_valid, c_out_ready;
`ifdef DEMUX_STREAM_ERR_EN
  logic        a_err, b_err, c_err;
`endif

  demux_stream #(.WIDTH(8), .N(8), .AUTO(0)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready)
`ifdef DEMUX_STREAM_ERR_EN
    , .err(a_err)
`endif
  );

  demux_stream #(.WIDTH(8), .N(3), .AUTO(1)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready)
`ifdef DEMUX_STREAM_ERR_EN
    , .err(b_err)
`endif
  );

  demux_stream #(.WIDTH(8), .N(6), .AUTO(0)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_sel(c_in_sel), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready)
`ifdef DEMUX_STREAM_ERR_EN
    , .err(c_err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  b_exp_v [7] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
  logic [23:0] b_exp_d [7] = '{24'h000010, 24'h001100, 24'h120000, 24'h000013,
                               24'h001400, 24'h150000, 24'h000016};

  initial begin
    rst = 1'b1;
    a_in_data = 8'hFF; a_in_sel = 3'd1; a_in_valid = 1'b1; a_out_ready = 8'hFF;
    b_in_data = 8'hFF; b_in_sel = 2'd2; b_in_valid = 1'b1; b_out_ready = 3'b111;
    c_in_data = 8'hFF; c_in_sel = 3'd1; c_in_valid = 1'b1; c_out_ready = 6'h3F;

    // Reset held two cycles with traffic offered
    tick();
    tick();
    rst = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    #1;
    chk("rst_a_valid", 64'(a_out_valid), 64'h0);
    chk("rst_a_data",  a_out_data,        64'h0);
    chk("rst_a_ready", 64'(a_in_ready),   64'h1);
    chk("rst_b_valid", 64'(b_out_valid),  64'h0);
    chk("rst_c_ready", 64'(c_in_ready),   64'h1);
`ifdef DEMUX_STREAM_ERR_EN
    chk("rst_c_err",   64'(c_err),        64'h0);
`endif

    // Routing to lane 5
    a_in_data = 8'hA5; a_in_sel = 3'd5; a_in_valid = 1'b1; a_out_ready = 8'hFF;
    tick();
    a_in_valid = 1'b0; a_out_ready = 8'hDF;
    #1;
    chk("route_valid", 64'(a_out_valid), 64'h20);
    chk("route_data",  a_out_data,       64'h0000A50000000000);
    chk("bp_in_ready", 64'(a_in_ready),  64'h0);

    // Backpressure: offered word must not disturb the held one
    a_in_valid = 1'b1; a_in_data = 8'h77; a_in_sel = 3'd1;
    tick();
    chk("bp_valid", 64'(a_out_valid), 64'h20);
    chk("bp_data",  a_out_data,       64'h0000A50000000000);

    // Release backpressure and switch channel without a bubble
    a_out_ready = 8'hFF; a_in_data = 8'h3C; a_in_sel = 3'd2;
    #1;
    chk("release_ready", 64'(a_in_ready), 64'h1);
    tick();
    chk("switch_valid", 64'(a_out_valid), 64'h04);
    chk("switch_data",  a_out_data,       64'h0000000000003C00 << 8);
    a_in_data = 8'h81; a_in_sel = 3'd7;
    tick();
    chk("b2b_valid", 64'(a_out_valid), 64'h80);
    chk("b2b_data",  a_out_data,       64'h8100000000000000);
    a_in_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(a_out_valid), 64'h0);

    // Reset mid-transfer discards the held word
    a_in_valid = 1'b1; a_in_data = 8'h42; a_in_sel = 3'd3; a_out_ready = 8'h00;
    tick();
    chk("pre_rst_valid", 64'(a_out_valid), 64'h08);
    a_in_data = 8'h99; a_in_sel = 3'd4; rst = 1'b1;
    tick();
    rst = 1'b0; a_in_valid = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(a_out_valid), 64'h0);
    chk("mid_rst_data",  a_out_data,       64'h0);
    chk("mid_rst_ready", 64'(a_in_ready),  64'h1);

    // AUTO mode: seven back-to-back accepts rotate 0,1,2,0,1,2,0; in_sel ignored
    b_out_ready = 3'b111; b_in_sel = 2'd2; b_in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      b_in_data = 8'(8'h10 + k);
      tick();
      chk($sformatf("auto_valid_%0d", k), 64'(b_out_valid), 64'(b_exp_v[k]));
      chk($sformatf("auto_data_%0d", k),  64'(b_out_data),  64'(b_exp_d[k]));
    end
    b_in_valid = 1'b0;
    tick();
    chk("auto_idle_valid", 64'(b_out_valid), 64'h0);
    tick();
    b_in_valid = 1'b1; b_in_data = 8'h5A;
    tick();
    b_in_valid = 1'b0;
    chk("auto_hold_ptr_valid", 64'(b_out_valid), 64'h2);
    chk("auto_hold_ptr_data",  64'(b_out_data),  64'h005A00);

    // Out-of-range select on N=6 with a simultaneous consume
    c_out_ready = 6'h3F; c_in_valid = 1'b1; c_in_sel = 3'd3; c_in_data = 8'h55;
    tick();
    chk("c_load_valid", 64'(c_out_valid), 64'h08);
    chk("c_load_data",  64'(c_out_data),  64'h000055000000);
    c_in_sel = 3'd7; c_in_data = 8'hEE;
    #1;
    chk("c_oor_ready", 64'(c_in_ready), 64'h1);
    tick();
    c_in_valid = 1'b0;
    chk("c_oor_valid", 64'(c_out_valid), 64'h0);
`ifdef DEMUX_STREAM_ERR_EN
    chk("c_err_pulse", 64'(c_err), 64'h1);
`endif
    tick();
    chk("c_after_valid", 64'(c_out_valid), 64'h0);
`ifdef DEMUX_STREAM_ERR_EN
    chk("c_err_clear", 64'(c_err), 64'h0);
`endif
    c_in_valid = 1'b1; c_in_sel = 3'd0; c_in_data = 8'h11;
    tick();
    c_in_valid = 1'b0;
    chk("c_recover_valid", 64'(c_out_valid), 64'h01);
    chk("c_recover_data",  64'(c_out_data),  64'h000000000011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits (1..64).
REQ-002 Parameter N, default 8: number of output channels (2..64); SELW = clog2(N) is derived.
REQ-003 Parameter AUTO, default 0: 0 = channel taken from in_sel; 1 = internal rotating pointer, in_sel ignored.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 in_data  input  WIDTH: word to route.
REQ-007 in_sel  input  SELW: destination channel (AUTO=0 only).
REQ-008 in_valid  input  1: in_data/in_sel valid.
REQ-009 in_ready  output  1: block accepts the word this cycle.
REQ-010 out_data  output  N*WIDTH: lane i is bits [i*WIDTH +: WIDTH].
REQ-011 out_valid  output  N: per-channel valid.
REQ-012 out_ready  input  N: per-channel ready.
REQ-013 err  output  1: out-of-range select pulse; present only with DEMUX_STREAM_ERR_EN.

Function
REQ-014 The block SHALL hold one word in a register set: hold_v, hold_d, hold_s.
REQ-015 in_ready SHALL be combinational: in_ready = !hold_v || out_ready[hold_s].
REQ-016 Accept: in_valid && in_ready loads hold_d=in_data, hold_s=target, hold_v=1 on the next edge.
  - Latency: accept to out_valid is exactly 1 cycle.
REQ-017 out_valid[i] SHALL equal hold_v && (hold_s == i).
  - out_data lane hold_s = hold_d; all other lanes = 0.
REQ-018 Consume: hold_v && out_ready[hold_s]; with no simultaneous accept, hold_v clears.
REQ-019 Simultaneous consume and accept SHALL reload the register in the same edge.
  - Gives 1 word/cycle sustained throughput, including a switch to a different channel.
REQ-020 While hold_v && !out_ready[hold_s], hold_d and hold_s SHALL stay stable.
  - out_ready of non-selected channels SHALL have no effect.
REQ-021 AUTO=1: pointer ptr starts at 0, is the target on every accept, and increments only on accept.
  - Wraps N-1 -> 0; holds otherwise.
REQ-022 Out-of-range select (AUTO=0, in_sel >= N, N not a power of 2): the word is accepted and dropped.
  - in_ready per REQ-015; hold registers unchanged, except hold_v clears on a simultaneous consume.
REQ-023 in_valid low SHALL never alter hold or ptr state.

Reset
REQ-024 On rst=1 at a clock edge SHALL set: hold_v=0, hold_s=0, hold_d=0, ptr=0, err=0.
  - Follows: all out_valid=0, all out_data=0, in_ready=1 from the next cycle.
REQ-025 Reset mid-transfer SHALL discard the held word; rst has priority over accept and consume.

Configuration
REQ-026 Macro DEMUX_STREAM_ERR_EN defined: port err exists.
  - Registered; high for exactly one cycle after each out-of-range accept.
REQ-027 Macro undefined: port err is absent and out-of-range words are dropped silently; all other behaviour is identical.

Structure
REQ-028 Shared package demux_pkg SHALL hold the WIDTH/N defaults and a clog2-based SELW helper constant function.
REQ-029 Sub-module demux_ptr: the AUTO-mode wrap counter (inputs clk, rst, inc; output ptr).
  - Instantiated only when AUTO=1.

Verification
REQ-030 Reset: rst high 2 cycles with in_valid=1 -> all out_valid=0, out_data=0, in_ready=1 after release.
REQ-031 Routing (N=8, AUTO=0): in_data=0xA5, in_sel=5, out_ready=8'hFF.
  - Next cycle: out_valid=8'b0010_0000, lane 5 = 0xA5, other lanes 0.
REQ-032 Backpressure: out_ready[5]=0 with word held -> in_ready=0, lane 5 stable 0xA5.
  - Raise out_ready[5] with in_valid, in_sel=2, data 0x3C -> next cycle out_valid=8'b0000_0100, no bubble.
REQ-033 AUTO=1, N=3: 7 back-to-back accepts with all ready -> channel sequence 0,1,2,0,1,2,0.
REQ-034 N=6 with DEMUX_STREAM_ERR_EN: in_sel=7 accepted -> no out_valid, err=1 for one cycle.
  - Repeat without macro -> word dropped silently.
